// File: rtl/pattern_gen_axis.sv
// pattern_gen_axis: multi-lane bus-test pattern source with a valid/ready stream.
// Finite or continuous bursts of eight deterministic patterns, with one-shot bit-0 error injection.
module pattern_gen_axis #(
   parameter int          WIDTH     = 64,
   parameter logic [31:0] LFSR_SEED = 32'h04030201,
   parameter int          LEN_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] fixed_pattern,
   input  logic [31:0]      seed,
   input  logic [LEN_W-1:0] length,
   input  logic             inject_err,
   output logic [WIDTH-1:0] tdata,
   output logic             tvalid,
   input  logic             tready,
   output logic             tlast,
   output logic             busy,
   output logic             done,
   output logic [31:0]      word_count
);

   localparam int LANES = WIDTH / 32;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       state;
   logic [2:0]       mode_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] k;
   logic [WIDTH-1:0] cur;
   logic [WIDTH-1:0] nb;
   logic [WIDTH-1:0] init_pat;
   logic [WIDTH-1:0] next_pat;
   logic [WIDTH-1:0] next_nb;
   logic [31:0]      eff_seed;
   logic [31:0]      lx;
   logic             inj_req;
   logic             inj_cur;
   logic             stop_pend;
   logic             run;
   logic             hs;
   logic             fin_last;
   logic             last;
   logic             inj_new;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> ((32 - n) % 32));
   endfunction

   assign run      = (state == S_RUN);
   assign hs       = run & tready;
   assign fin_last = (len_q != '0) && (k == len_q - LEN_W'(1));
   assign last     = fin_last | stop_pend;
   // A pulse while the corrupted word is already on the bus merges into it.
   assign inj_new  = inject_err & ~inj_cur;

   assign tvalid = run;
   assign busy   = run;
   assign tlast  = run & fin_last;
   assign tdata  = run ? (cur ^ WIDTH'(inj_cur)) : '0;

   always_comb begin
      eff_seed = (seed == 32'd0) ? LFSR_SEED : seed;
      init_pat = '0;
      unique case (mode)
         3'b000: for (int i = 0; i < LANES; i++)
            init_pat[32*i +: 32] = 32'(i);
         3'b001: for (int i = 0; i < LANES; i++)
            init_pat[32*i +: 32] = rotl(eff_seed, (8 * i) % 32);
         3'b010: init_pat = WIDTH'(1);
         3'b011: init_pat = ~WIDTH'(1);
         3'b100: init_pat = '1;
         3'b101: init_pat = ~WIDTH'(1);
         3'b110: init_pat = fixed_pattern;
         default: init_pat = '0;
      endcase
   end

   // nb tracks the zero position of the neighbor pattern across odd words.
   always_comb begin
      next_pat = cur;
      next_nb  = nb;
      lx       = '0;
      unique case (mode_q)
         3'b000: for (int i = 0; i < LANES; i++)
            next_pat[32*i +: 32] = cur[32*i +: 32] + 32'(LANES);
         3'b001: for (int i = 0; i < LANES; i++) begin
            lx = cur[32*i +: 32];
            next_pat[32*i +: 32] = {lx[30:0], lx[31] ^ lx[21] ^ lx[1]};
         end
         3'b010, 3'b011: next_pat = {cur[WIDTH-2:0], cur[WIDTH-1]};
         3'b100: next_pat = ~cur;
         3'b101: begin
            if (!k[0]) begin
               next_pat = '0;
            end else begin
               next_nb  = {nb[WIDTH-2:0], nb[WIDTH-1]};
               next_pat = ~next_nb;
            end
         end
         default: next_pat = cur;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         mode_q     <= '0;
         len_q      <= '0;
         k          <= '0;
         cur        <= '0;
         nb         <= '0;
         inj_req    <= 1'b0;
         inj_cur    <= 1'b0;
         stop_pend  <= 1'b0;
         done       <= 1'b0;
         word_count <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_RUN;
                  mode_q     <= mode;
                  len_q      <= length;
                  k          <= '0;
                  cur        <= init_pat;
                  nb         <= WIDTH'(1);
                  inj_req    <= 1'b0;
                  inj_cur    <= 1'b0;
                  stop_pend  <= 1'b0;
                  word_count <= '0;
               end
            end
            S_RUN: begin
               if (stop)
                  stop_pend <= 1'b1;
               if (hs) begin
                  word_count <= word_count + 32'd1;
                  k          <= k + LEN_W'(1);
                  cur        <= next_pat;
                  nb         <= next_nb;
                  inj_cur    <= inj_req | inj_new;
                  inj_req    <= 1'b0;
                  if (last) begin
                     state     <= S_IDLE;
                     done      <= 1'b1;
                     stop_pend <= 1'b0;
                     inj_cur   <= 1'b0;
                  end
               end else if (inj_new) begin
                  // Word on the bus stays clean; the next one carries the error.
                  inj_req <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_gen_axis.sv
// tb_pattern_gen_axis: scoreboard bench for pattern_gen_axis (WIDTH=64).
// Inputs change on the falling edge; outputs are sampled there too.
module tb_pattern_gen_axis;

   localparam int WIDTH = 64;
   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             stop;
   logic [2:0]       mode;
   logic [WIDTH-1:0] fixed_pattern;
   logic [31:0]      seed;
   logic [LEN_W-1:0] length;
   logic             inject_err;
   logic [WIDTH-1:0] tdata;
   logic             tvalid;
   logic             tready;
   logic             tlast;
   logic             busy;
   logic             done;
   logic [31:0]      word_count;

   int n_checks = 0;
   int n_fail   = 0;

   // {tlast, tdata} expected per transferred word
   logic [WIDTH:0] sb[$];

   always #5 clk = ~clk;

   pattern_gen_axis #(
      .WIDTH(WIDTH),
      .LFSR_SEED(32'h04030201),
      .LEN_W(LEN_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .stop(stop),
      .mode(mode),
      .fixed_pattern(fixed_pattern),
      .seed(seed),
      .length(length),
      .inject_err(inject_err),
      .tdata(tdata),
      .tvalid(tvalid),
      .tready(tready),
      .tlast(tlast),
      .busy(busy),
      .done(done),
      .word_count(word_count)
   );

   function automatic logic [WIDTH-1:0] cnt_word(input int k);
      return {32'(2 * k + 1), 32'(2 * k)};
   endfunction

   function automatic logic [WIDTH-1:0] nbr_word(input int k);
      logic [WIDTH-1:0] one;
      one = WIDTH'(1);
      if (k % 2 == 0) return ~(one << ((k / 2) % WIDTH));
      return '0;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (tvalid !== 1'b0) begin n_fail++; $display("FAIL reset tvalid: got %b want 0", tvalid); end
      n_checks++;
      if (tlast !== 1'b0) begin n_fail++; $display("FAIL reset tlast: got %b want 0", tlast); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", done); end
      n_checks++;
      if (tdata !== '0) begin n_fail++; $display("FAIL reset tdata: got %h want 0", tdata); end
      n_checks++;
      if (word_count !== 32'd0) begin n_fail++; $display("FAIL reset word_count: got %0d want 0", word_count); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_counter();
      logic [WIDTH:0] e;
      int cyc;
      mode = 3'b000; length = 16'd4; tready = 1'b1; start = 1'b1;
      for (int k = 0; k < 4; k++) sb.push_back({k == 3, cnt_word(k)});
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (sb.size() > 0 && cyc < 50) begin
         tready = 1'b1;
         if (tvalid && tready) begin
            e = sb.pop_front();
            n_checks++;
            if (tdata !== e[WIDTH-1:0] || tlast !== e[WIDTH]) begin
               n_fail++;
               $display("FAIL counter word: got %h/%b want %h/%b", tdata, tlast, e[WIDTH-1:0], e[WIDTH]);
            end
         end
         @(negedge clk); cyc++;
      end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL counter timeout: %0d words left want 0", sb.size()); sb.delete(); end
      n_checks++;
      if (done !== 1'b1 || tvalid !== 1'b0) begin n_fail++; $display("FAIL counter done: got done=%b tvalid=%b want 1/0", done, tvalid); end
      n_checks++;
      if (word_count !== 32'd4) begin n_fail++; $display("FAIL counter word_count: got %0d want 4", word_count); end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL counter done width: got %b want 0", done); end
   endtask

   task automatic test_lfsr();
      logic [WIDTH:0] e;
      logic [31:0] l0, l1;
      int cyc, idx;
      l0 = 32'h04030201;
      l1 = {l0[23:0], l0[31:24]};
      for (int k = 0; k < 1000; k++) begin
         sb.push_back({k == 999, l1, l0});
         l0 = {l0[30:0], l0[31] ^ l0[21] ^ l0[1]};
         l1 = {l1[30:0], l1[31] ^ l1[21] ^ l1[1]};
      end
      mode = 3'b001; seed = 32'd0; length = 16'd1000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seed = 32'hFFFF_0000;
      cyc = 0; idx = 0;
      while (sb.size() > 0 && cyc < 1200) begin
         tready = 1'b1;
         if (tvalid && tready) begin
            if (idx == 1) begin
               n_checks++;
               if (tdata[31:0] !== 32'h08060402) begin n_fail++; $display("FAIL lfsr word1: got %h want 08060402", tdata[31:0]); end
            end
            e = sb.pop_front();
            n_checks++;
            if (tdata !== e[WIDTH-1:0] || tlast !== e[WIDTH]) begin
               n_fail++;
               $display("FAIL lfsr word %0d: got %h/%b want %h/%b", idx, tdata, tlast, e[WIDTH-1:0], e[WIDTH]);
            end
            idx++;
         end
         @(negedge clk); cyc++;
      end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL lfsr timeout: %0d words left want 0", sb.size()); sb.delete(); end
      n_checks++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL lfsr done: got %b want 1", done); end
   endtask

   task automatic test_walk();
      logic [WIDTH:0] e;
      logic [WIDTH-1:0] one;
      int cyc;
      one = WIDTH'(1);
      for (int k = 0; k < 66; k++) sb.push_back({k == 65, one << (k % WIDTH)});
      mode = 3'b010; length = 16'd66; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (sb.size() > 0 && cyc < 100) begin
         tready = 1'b1;
         if (tvalid && tready) begin
            e = sb.pop_front();
            n_checks++;
            if (tdata !== e[WIDTH-1:0] || tlast !== e[WIDTH]) begin
               n_fail++;
               $display("FAIL walk word %0d: got %h/%b want %h/%b", 65 - sb.size(), tdata, tlast, e[WIDTH-1:0], e[WIDTH]);
            end
         end
         @(negedge clk); cyc++;
      end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL walk timeout: %0d words left want 0", sb.size()); sb.delete(); end
      n_checks++;
      if (done !== 1'b1 || word_count !== 32'd66) begin n_fail++; $display("FAIL walk end: got done=%b count=%0d want 1/66", done, word_count); end
   endtask

   task automatic test_hammer_stall();
      logic [WIDTH:0] e;
      logic [WIDTH-1:0] hold_d;
      logic hold_l, hold_v;
      bit inj_done;
      int cyc, idx;
      for (int k = 0; k < 20; k++)
         sb.push_back({k == 19, ((k % 2 == 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}}) ^ WIDTH'(k == 6)});
      mode = 3'b100; length = 16'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0; idx = 0; hold_v = 1'b0; inj_done = 1'b0;
      hold_d = '0; hold_l = 1'b0;
      while (sb.size() > 0 && cyc < 300) begin
         if (hold_v) begin
            n_checks++;
            if (tdata !== hold_d || tlast !== hold_l) begin
               n_fail++;
               $display("FAIL stall stability: got %h/%b want %h/%b", tdata, tlast, hold_d, hold_l);
            end
         end
         inject_err = 1'b0;
         tready = ($urandom_range(0, 99) >= 40);
         // stall word 5 and inject while it waits: word 6 must take the error
         if (idx == 5 && !inj_done) begin tready = 1'b0; inject_err = 1'b1; inj_done = 1'b1; end
         start = (idx == 8);
         hold_v = tvalid && !tready;
         hold_d = tdata; hold_l = tlast;
         if (tvalid && tready) begin
            e = sb.pop_front();
            n_checks++;
            if (tdata !== e[WIDTH-1:0] || tlast !== e[WIDTH]) begin
               n_fail++;
               $display("FAIL hammer word %0d: got %h/%b want %h/%b", idx, tdata, tlast, e[WIDTH-1:0], e[WIDTH]);
            end
            idx++;
         end
         @(negedge clk); cyc++;
      end
      inject_err = 1'b0; start = 1'b0; tready = 1'b1;
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL hammer timeout: %0d words left want 0", sb.size()); sb.delete(); end
      n_checks++;
      if (done !== 1'b1 || word_count !== 32'd20) begin n_fail++; $display("FAIL hammer end: got done=%b count=%0d want 1/20", done, word_count); end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH:0] e;
      logic [WIDTH-1:0] f1, f2;
      int cyc;
      f1 = 64'hDEAD_BEEF_0123_4567;
      f2 = 64'h55AA_33CC_0F0F_F00F;
      mode = 3'b110; fixed_pattern = f1; length = 16'd1; start = 1'b1;
      sb.push_back({1'b1, f1});
      @(negedge clk);
      start = 1'b0; fixed_pattern = '0;
      cyc = 0;
      while (sb.size() > 0 && cyc < 20) begin
         tready = 1'b1;
         if (tvalid && tready) begin
            e = sb.pop_front();
            n_checks++;
            if (tdata !== e[WIDTH-1:0] || tlast !== e[WIDTH]) begin
               n_fail++;
               $display("FAIL single word: got %h/%b want %h/%b", tdata, tlast, e[WIDTH-1:0], e[WIDTH]);
            end
         end
         @(negedge clk); cyc++;
      end
      n_checks++;
      if (sb.size() != 0 || done !== 1'b1) begin n_fail++; $display("FAIL single end: got left=%0d done=%b want 0/1", sb.size(), done); sb.delete(); end
      // restart in the same cycle as done
      fixed_pattern = f2; length = 16'd2; start = 1'b1;
      sb.push_back({1'b0, f2});
      sb.push_back({1'b1, f2});
      @(negedge clk);
      start = 1'b0; fixed_pattern = '0; mode = 3'b000;
      n_checks++;
      if (tvalid !== 1'b1) begin n_fail++; $display("FAIL start on done: got tvalid=%b want 1", tvalid); end
      cyc = 0;
      while (sb.size() > 0 && cyc < 20) begin
         tready = 1'b1;
         start = (sb.size() == 2);
         if (tvalid && tready) begin
            e = sb.pop_front();
            n_checks++;
            if (tdata !== e[WIDTH-1:0] || tlast !== e[WIDTH]) begin
               n_fail++;
               $display("FAIL back_to_back word: got %h/%b want %h/%b", tdata, tlast, e[WIDTH-1:0], e[WIDTH]);
            end
         end
         @(negedge clk); cyc++;
      end
      start = 1'b0;
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL back_to_back timeout: %0d left want 0", sb.size()); sb.delete(); end
      n_checks++;
      if (done !== 1'b1 || word_count !== 32'd2) begin n_fail++; $display("FAIL back_to_back end: got done=%b count=%0d want 1/2", done, word_count); end
      @(negedge clk);
   endtask

   task automatic test_inject_stop();
      logic [WIDTH:0] e;
      int cyc, idx;
      // both pulses in IDLE must be ignored
      inject_err = 1'b1; stop = 1'b1;
      @(negedge clk);
      inject_err = 1'b0; stop = 1'b0;
      for (int k = 0; k < 21; k++) sb.push_back({1'b0, cnt_word(k) ^ WIDTH'(k == 10)});
      mode = 3'b000; length = 16'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0; idx = 0;
      while (sb.size() > 0 && cyc < 100) begin
         tready = 1'b1;
         inject_err = (idx == 9);
         stop = (idx == 19);
         if (tvalid && tready) begin
            e = sb.pop_front();
            n_checks++;
            if (tdata !== e[WIDTH-1:0] || tlast !== e[WIDTH]) begin
               n_fail++;
               $display("FAIL inject/stop word %0d: got %h/%b want %h/%b", idx, tdata, tlast, e[WIDTH-1:0], e[WIDTH]);
            end
            idx++;
         end
         @(negedge clk); cyc++;
      end
      inject_err = 1'b0; stop = 1'b0;
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL inject/stop timeout: %0d left want 0", sb.size()); sb.delete(); end
      n_checks++;
      if (done !== 1'b1 || tvalid !== 1'b0) begin n_fail++; $display("FAIL stop end: got done=%b tvalid=%b want 1/0", done, tvalid); end
      n_checks++;
      if (word_count !== 32'd21) begin n_fail++; $display("FAIL stop word_count: got %0d want 21", word_count); end
   endtask

   task automatic test_reset_mid();
      logic [WIDTH:0] e;
      int cyc;
      for (int k = 0; k < 5; k++) sb.push_back({1'b0, nbr_word(k)});
      mode = 3'b101; length = 16'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (sb.size() > 0 && cyc < 20) begin
         tready = 1'b1;
         if (tvalid && tready) begin
            e = sb.pop_front();
            n_checks++;
            if (tdata !== e[WIDTH-1:0] || tlast !== e[WIDTH]) begin
               n_fail++;
               $display("FAIL neighbor pre-reset: got %h/%b want %h/%b", tdata, tlast, e[WIDTH-1:0], e[WIDTH]);
            end
         end
         @(negedge clk); cyc++;
      end
      n_checks++;
      if (busy !== 1'b1 || sb.size() != 0) begin n_fail++; $display("FAIL neighbor running: got busy=%b left=%0d want 1/0", busy, sb.size()); sb.delete(); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks++;
      if (tvalid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid reset: got tvalid=%b done=%b want 0/0", tvalid, done); end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL post reset: got done=%b busy=%b want 0/0", done, busy); end
      for (int k = 0; k < 3; k++) sb.push_back({k == 2, nbr_word(k)});
      mode = 3'b101; length = 16'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (sb.size() > 0 && cyc < 20) begin
         tready = 1'b1;
         if (tvalid && tready) begin
            e = sb.pop_front();
            n_checks++;
            if (tdata !== e[WIDTH-1:0] || tlast !== e[WIDTH]) begin
               n_fail++;
               $display("FAIL neighbor restart: got %h/%b want %h/%b", tdata, tlast, e[WIDTH-1:0], e[WIDTH]);
            end
         end
         @(negedge clk); cyc++;
      end
      n_checks++;
      if (sb.size() != 0 || done !== 1'b1) begin n_fail++; $display("FAIL neighbor end: got left=%0d done=%b want 0/1", sb.size(), done); sb.delete(); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; mode = '0;
      fixed_pattern = '0; seed = '0; length = '0;
      inject_err = 1'b0; tready = 1'b1;
      test_reset();
      test_counter();
      test_lfsr();
      test_walk();
      test_hammer_stall();
      test_back_to_back();
      test_inject_stop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
